disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Time-multiplexed scan controller for the digital clock's 7-segment display. It holds a frame of BCD digits and drives one shared `dec7` decoder and the per-digit anode enables, one digit at a time. It inserts a blanking guard between digits to suppress ghosting, and swaps in new digit data only at frame boundaries so the display never tears. It sits between the timekeeping counters (which `load` new digits) and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 6, number of multiplexed digits (2..8)
- REFRESH_DIV, 1000, clk cycles per digit slot, including blanking
- BLANK_CYCLES, 8, cycles per slot with all anodes off (1 ≤ BLANK_CYCLES < REFRESH_DIV)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scan enable; low forces the display dark
- load  in  1  one-cycle strobe that captures `digits_in` and `dp_in` into the shadow register
- digits_in  in  4*NUM_DIGITS  BCD digits; digit 0 occupies bits [3:0] and is the least significant digit
- dp_in  in  NUM_DIGITS  decimal-point request per digit
- lz_en  in  1  leading-zero suppression enable
- dec_bcd  out  4  registered code sent to the shared `dec7`; 4'hF means blank, because `dec7` decodes it to all segments off
- an_n  out  NUM_DIGITS  registered active-low anode enables
- dp_out  out  1  registered decimal point for the current digit
- frame_done  out  1  one-cycle pulse at the end of each full frame

## Operation
- Registers:
  - shadow: digits and dp, written on `load`
  - active: digits and dp, used for display
  - pending: flag set by `load`
  - idx: current digit index, 0..NUM_DIGITS-1
  - slot counter: counts 0..REFRESH_DIV-1
- States:
  - IDLE: all anodes off.
  - BLANK: `dec_bcd` already shows digit idx; all anodes off.
  - DRIVE: `an_n[idx]` = 0.
- Transitions:
  - IDLE → BLANK when `enable` = 1. On this transition: idx = 0, slot counter = 0, and active ← shadow if pending was set (pending then clears).
  - BLANK → DRIVE when the slot counter reaches BLANK_CYCLES-1.
  - DRIVE → BLANK when the slot counter reaches REFRESH_DIV-1. idx increments and wraps from NUM_DIGITS-1 to 0.
  - On the wrap (idx NUM_DIGITS-1 → 0): `frame_done` = 1 for that cycle, and active ← shadow if pending was set before this cycle.
  - Any state → IDLE when `enable` = 0. In IDLE: idx = 0, slot counter = 0, and `frame_done` is not pulsed.
- Load:
  - `load` writes shadow and sets pending in the same edge.
  - A load on the same cycle as a commit is not committed at that boundary. It stays pending until the next boundary.
  - A second load before a commit overwrites shadow; the last load wins.
- Digit code: `dec_bcd` = active digit[idx], passed through unmodified. Values above 9 pass through, so `dec7` blanks them.
- Leading-zero suppression: with `lz_en` = 1, digit i > 0 is suppressed when it and every more-significant digit are 0. A suppressed digit shows `dec_bcd` = 4'hF and `dp_out` = 0. Digit 0 is never suppressed.
- Decimal point: `dp_out` = active dp[idx] only in DRIVE; 0 otherwise.

## Timing
- Reset values:
  - Outputs: `an_n` all 1, `dec_bcd` = 4'hF, `dp_out` = 0, `frame_done` = 0.
  - Internal: state IDLE; shadow, active and pending all 0.
- All outputs are registered; nothing combinational reaches the pins.
- Start-up: from `enable` rising (sampled at edge N), BLANK is entered at N+1, and the first anode asserts at N+1+BLANK_CYCLES.
- Slot timing: each slot is exactly REFRESH_DIV cycles, BLANK_CYCLES dark then REFRESH_DIV-BLANK_CYCLES lit. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- `dec_bcd` changes only on entry to BLANK, never while an anode is on.
- At most one `an_n` bit is 0 in any cycle.
- Reset mid-frame: outputs return to reset values immediately (asynchronous) and pending data is lost.
- `enable` falling mid-DRIVE: `an_n` returns to all 1 on the next edge.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=10, BLANK_CYCLES=2.
- **Reset/idle.** Assert `rst` mid-DRIVE → `an_n`=4'b1111, `dec_bcd`=4'hF and `frame_done`=0 asynchronously; they stay there while `enable`=0.
- **Basic scan.** Load 16'h4321, raise `enable` → per digit: 2 cycles dark, then 8 cycles with `an_n`=1110, 1101, 1011, 0111 in turn, showing `dec_bcd` 1, 2, 3, 4; `frame_done` pulses every 40 cycles.
- **Tear-free update.** Load 16'h9999 mid-frame → digits continue to show 1-4 until the wrap; 9s appear from the next frame. A load in the same cycle as `frame_done` is committed one frame later.
- **Leading zeros.** With `lz_en`=1, load 16'h0070 → digits 3 and 2 show `dec_bcd`=4'hF; digit 1 shows 7; digit 0 shows 0.
- **Decimal point.** Set `dp_in`=4'b0100 → `dp_out`=1 only during digit 2's DRIVE cycles, and 0 in BLANK.
- **Enable drop.** Drop `enable` during digit 2 → next cycle `an_n`=4'b1111. Re-enabling restarts at digit 0 after 2 blank cycles.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Digit-load and display-pin bundle between the timekeeping logic and the
// 7-segment scan controller.
interface disp_scan_ctrl_if #(
   parameter int NUM_DIGITS = 6
);
   logic                      enable;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      lz_en;
   logic [3:0]                dec_bcd;
   logic [NUM_DIGITS-1:0]     an_n;
   logic                      dp_out;
   logic                      frame_done;

   modport master (
      output enable, load, digits_in, dp_in, lz_en,
      input  dec_bcd, an_n, dp_out, frame_done
   );

   modport slave (
      input  enable, load, digits_in, dp_in, lz_en,
      output dec_bcd, an_n, dp_out, frame_done
   );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared decoder code, per-digit
// anode enables, blanking guard per slot and frame-boundary data swap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | scan disabled, display dark, idx and slot timer parked
// S_BLANK | guard interval, dec_bcd set up for digit idx, anodes off
// S_DRIVE | anode idx on, dec_bcd held, dp shown
module disp_scan_ctrl #(
   parameter int NUM_DIGITS   = 6,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 8
) (
   input  logic            clk,
   input  logic            rst,
   disp_scan_ctrl_if.slave bus
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] SLOT_LIT  = CW'(REFRESH_DIV - BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [CW-1:0]           slot_q, slot_d;
   logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0] active_dig_q, active_dig_d;
   logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
   logic                    pending_q, pending_d;
   logic                    sup_q, sup_d;
   logic [3:0]              dec_bcd_q, dec_bcd_d;
   logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
   logic                    dp_out_q, dp_out_d;
   logic                    frame_done_q, frame_done_d;

   logic                    wrap;
   logic                    commit;
   logic [3:0]              cur_dig;
   logic                    cur_dp;
   logic                    hi_nonzero;
   logic                    suppress;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         slot_q       <= SLOT_LAST;
         shadow_dig_q <= '0;
         shadow_dp_q  <= '0;
         active_dig_q <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         sup_q        <= 1'b0;
         dec_bcd_q    <= 4'hF;
         an_n_q       <= '1;
         dp_out_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         slot_q       <= slot_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_dp_q  <= shadow_dp_d;
         active_dig_q <= active_dig_d;
         active_dp_q  <= active_dp_d;
         pending_q    <= pending_d;
         sup_q        <= sup_d;
         dec_bcd_q    <= dec_bcd_d;
         an_n_q       <= an_n_d;
         dp_out_q     <= dp_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   // slot_q is a down-counter of cycles left in the slot; the lit phase
   // starts once BLANK_CYCLES of it have elapsed.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      slot_d  = slot_q;
      wrap    = 1'b0;
      commit  = 1'b0;
      if (!bus.enable) begin
         state_d = S_IDLE;
         idx_d   = '0;
         slot_d  = SLOT_LAST;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_BLANK;
               idx_d   = '0;
               slot_d  = SLOT_LAST;
               commit  = 1'b1;
            end
            S_BLANK: begin
               slot_d = slot_q - 1'b1;
               if (slot_q == SLOT_LIT) begin
                  state_d = S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (slot_q == '0) begin
                  state_d = S_BLANK;
                  slot_d  = SLOT_LAST;
                  if (idx_q == IDX_LAST) begin
                     idx_d  = '0;
                     wrap   = 1'b1;
                     commit = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  slot_d = slot_q - 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A load landing on a commit edge only refreshes shadow and keeps pending
   // set, so it is picked up at the following boundary.
   always_comb begin
      shadow_dig_d = shadow_dig_q;
      shadow_dp_d  = shadow_dp_q;
      active_dig_d = active_dig_q;
      active_dp_d  = active_dp_q;
      pending_d    = pending_q;
      if (commit && pending_q) begin
         active_dig_d = shadow_dig_q;
         active_dp_d  = shadow_dp_q;
         pending_d    = 1'b0;
      end
      if (bus.load) begin
         shadow_dig_d = bus.digits_in;
         shadow_dp_d  = bus.dp_in;
         pending_d    = 1'b1;
      end
   end

   always_comb begin
      cur_dig    = 4'h0;
      cur_dp     = 1'b0;
      hi_nonzero = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_dig = active_dig_q[4*i +: 4];
            cur_dp  = active_dp_q[i];
         end
         if ((IW'(i) >= idx_q) && (active_dig_q[4*i +: 4] != 4'h0)) begin
            hi_nonzero = 1'b1;
         end
      end
      suppress = bus.lz_en && (idx_q != '0) && !hi_nonzero;

      an_n_d       = '1;
      dec_bcd_d    = 4'hF;
      dp_out_d     = 1'b0;
      sup_d        = sup_q;
      frame_done_d = 1'b0;
      // The code is latched on the first guard cycle so nothing on the
      // segment bus moves while an anode is on.
      if (bus.enable) begin
         case (state_q)
            S_BLANK: begin
               if (slot_q == SLOT_LAST) begin
                  sup_d     = suppress;
                  dec_bcd_d = suppress ? 4'hF : cur_dig;
               end else begin
                  dec_bcd_d = dec_bcd_q;
               end
            end
            S_DRIVE: begin
               dec_bcd_d    = dec_bcd_q;
               dp_out_d     = cur_dp & ~sup_q;
               frame_done_d = wrap;
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (idx_q == IW'(i)) begin
                     an_n_d[i] = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.dec_bcd    = dec_bcd_q;
   assign bus.an_n       = an_n_q;
   assign bus.dp_out     = dp_out_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position model checked every cycle plus
// directed literal expectations at chosen scan positions.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;
   localparam int ND = 4;
   localparam int RD = 10;
   localparam int BC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   n0 = 0;

   disp_scan_ctrl_if #(.NUM_DIGITS(ND)) ifc();

   disp_scan_ctrl #(
      .NUM_DIGITS(ND),
      .REFRESH_DIV(RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Model: outputs are a function of position p since the scan started.
   // p = -1 on the enabling edge, then slot = p/RD, within-slot = p%RD.
   logic [4*ND-1:0] m_sh = '0, m_act = '0;
   logic [ND-1:0]   m_sh_dp = '0, m_act_dp = '0;
   bit              m_pend = 0, m_run = 0, m_sup = 0;
   int              m_p = 0, m_dig = 0, m_within = 0;
   logic [3:0]      m_code = 4'hF;
   logic [ND-1:0]   exp_an = '1;
   logic [3:0]      exp_bcd = 4'hF;
   logic            exp_dp = 1'b0, exp_fd = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sh = '0; m_act = '0; m_sh_dp = '0; m_act_dp = '0;
         m_pend = 0; m_run = 0;
         exp_an = '1; exp_bcd = 4'hF; exp_dp = 1'b0; exp_fd = 1'b0;
      end else begin
         exp_an = '1; exp_dp = 1'b0; exp_fd = 1'b0;
         if (!ifc.enable) begin
            m_run = 0;
            exp_bcd = 4'hF;
         end else if (!m_run) begin
            m_run = 1;
            m_p = -1;
            exp_bcd = 4'hF;
            if (m_pend) begin m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 0; end
         end else begin
            m_p++;
            m_dig = (m_p / RD) % ND;
            m_within = m_p % RD;
            if (m_within == 0) begin
               m_sup = ifc.lz_en && (m_dig > 0) && ((m_act >> (4*m_dig)) == 0);
               m_code = m_sup ? 4'hF : m_act[4*m_dig +: 4];
            end
            exp_bcd = m_code;
            if (m_within >= BC) begin
               exp_an[m_dig] = 1'b0;
               exp_dp = m_act_dp[m_dig] && !m_sup;
            end
            if (m_within == RD-1 && m_dig == ND-1) begin
               exp_fd = 1'b1;
               if (m_pend) begin m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 0; end
            end
         end
         if (ifc.load) begin
            m_sh = ifc.digits_in; m_sh_dp = ifc.dp_in; m_pend = 1;
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (ifc.an_n !== exp_an) begin
         failures++;
         $display("FAIL scan_an_n t=%0t got=%b exp=%b", $time, ifc.an_n, exp_an);
      end
      checks++;
      if (ifc.dec_bcd !== exp_bcd) begin
         failures++;
         $display("FAIL scan_dec_bcd t=%0t got=%h exp=%h", $time, ifc.dec_bcd, exp_bcd);
      end
      checks++;
      if (ifc.dp_out !== exp_dp) begin
         failures++;
         $display("FAIL scan_dp_out t=%0t got=%b exp=%b", $time, ifc.dp_out, exp_dp);
      end
      checks++;
      if (ifc.frame_done !== exp_fd) begin
         failures++;
         $display("FAIL scan_frame_done t=%0t got=%b exp=%b", $time, ifc.frame_done, exp_fd);
      end
      checks++;
      if ($countones(~ifc.an_n) > 1) begin
         failures++;
         $display("FAIL one_anode t=%0t got=%b exp=at most one low", $time, ifc.an_n);
      end
   end

   task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, want);
      end
   endtask

   task automatic tick_to(input int rel);
      while (cyc - n0 < rel) @(negedge clk);
   endtask

   task automatic start_scan();
      ifc.enable = 1'b1;
      @(negedge clk);
      n0 = cyc;
   endtask

   task automatic do_load(input logic [15:0] dig, input logic [3:0] dp);
      ifc.load = 1'b1;
      ifc.digits_in = dig;
      ifc.dp_in = dp;
      @(negedge clk);
      ifc.load = 1'b0;
   endtask

   initial begin
      ifc.enable = 1'b0;
      ifc.load = 1'b0;
      ifc.digits_in = '0;
      ifc.dp_in = '0;
      ifc.lz_en = 1'b0;
      repeat (2) @(negedge clk);
      lit("rst_an_n", 16'(ifc.an_n), 16'hF);
      lit("rst_dec_bcd", 16'(ifc.dec_bcd), 16'hF);
      lit("rst_dp_out", 16'(ifc.dp_out), 16'h0);
      lit("rst_frame_done", 16'(ifc.frame_done), 16'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // basic scan of 4321
      do_load(16'h4321, 4'b0000);
      @(negedge clk);
      start_scan();
      lit("start_dark", 16'(ifc.an_n), 16'hF);
      tick_to(1);
      lit("blank0_bcd", 16'(ifc.dec_bcd), 16'h1);
      lit("blank0_an", 16'(ifc.an_n), 16'hF);
      tick_to(3);
      lit("d0_an", 16'(ifc.an_n), 16'hE);
      lit("d0_bcd", 16'(ifc.dec_bcd), 16'h1);
      tick_to(13);
      lit("d1_an", 16'(ifc.an_n), 16'hD);
      lit("d1_bcd", 16'(ifc.dec_bcd), 16'h2);
      tick_to(39);
      lit("fd_early", 16'(ifc.frame_done), 16'h0);
      tick_to(40);
      lit("fd_wrap", 16'(ifc.frame_done), 16'h1);
      lit("d3_an", 16'(ifc.an_n), 16'h7);
      lit("d3_bcd", 16'(ifc.dec_bcd), 16'h4);
      tick_to(41);
      lit("fd_single", 16'(ifc.frame_done), 16'h0);
      lit("f1_blank_an", 16'(ifc.an_n), 16'hF);

      // tear-free update, and a load in the frame_done cycle
      tick_to(50);
      do_load(16'h9999, 4'b0000);
      tick_to(63);
      lit("tear_hold_bcd", 16'(ifc.dec_bcd), 16'h3);
      lit("tear_hold_an", 16'(ifc.an_n), 16'hB);
      tick_to(80);
      lit("fd_frame1", 16'(ifc.frame_done), 16'h1);
      do_load(16'h5678, 4'b0000);
      tick_to(83);
      lit("new9_d0", 16'(ifc.dec_bcd), 16'h9);
      tick_to(113);
      lit("new9_d3", 16'(ifc.dec_bcd), 16'h9);
      lit("new9_d3_an", 16'(ifc.an_n), 16'h7);
      tick_to(123);
      lit("late_load_d0", 16'(ifc.dec_bcd), 16'h8);

      // leading-zero suppression of 0070
      tick_to(130);
      ifc.lz_en = 1'b1;
      do_load(16'h0070, 4'b0000);
      tick_to(163);
      lit("lz_d0", 16'(ifc.dec_bcd), 16'h0);
      tick_to(173);
      lit("lz_d1", 16'(ifc.dec_bcd), 16'h7);
      tick_to(183);
      lit("lz_d2", 16'(ifc.dec_bcd), 16'hF);
      lit("lz_d2_an", 16'(ifc.an_n), 16'hB);
      tick_to(193);
      lit("lz_d3", 16'(ifc.dec_bcd), 16'hF);

      // decimal point on digit 2
      tick_to(195);
      do_load(16'h4321, 4'b0100);
      tick_to(221);
      lit("dp_blank", 16'(ifc.dp_out), 16'h0);
      lit("dp_blank_bcd", 16'(ifc.dec_bcd), 16'h3);
      tick_to(223);
      lit("dp_lit", 16'(ifc.dp_out), 16'h1);
      lit("dp_lit_an", 16'(ifc.an_n), 16'hB);
      tick_to(230);
      lit("dp_last", 16'(ifc.dp_out), 16'h1);
      tick_to(231);
      lit("dp_next_blank", 16'(ifc.dp_out), 16'h0);
      tick_to(233);
      lit("dp_d3", 16'(ifc.dp_out), 16'h0);

      // enable drop during digit 2, then restart
      tick_to(265);
      ifc.enable = 1'b0;
      tick_to(266);
      lit("drop_an", 16'(ifc.an_n), 16'hF);
      lit("drop_bcd", 16'(ifc.dec_bcd), 16'hF);
      tick_to(268);
      lit("drop_fd", 16'(ifc.frame_done), 16'h0);
      start_scan();
      tick_to(1);
      lit("restart_bcd", 16'(ifc.dec_bcd), 16'h1);
      tick_to(2);
      lit("restart_dark", 16'(ifc.an_n), 16'hF);
      tick_to(3);
      lit("restart_an", 16'(ifc.an_n), 16'hE);

      // async reset mid-drive drops pending data
      tick_to(4);
      do_load(16'h8888, 4'b1111);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      lit("async_an", 16'(ifc.an_n), 16'hF);
      lit("async_bcd", 16'(ifc.dec_bcd), 16'hF);
      lit("async_dp", 16'(ifc.dp_out), 16'h0);
      lit("async_fd", 16'(ifc.frame_done), 16'h0);
      ifc.enable = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      lit("post_rst_an", 16'(ifc.an_n), 16'hF);
      start_scan();
      tick_to(3);
      lit("lost_pend_d0", 16'(ifc.dec_bcd), 16'h0);
      lit("lost_pend_an", 16'(ifc.an_n), 16'hE);
      tick_to(13);
      lit("lost_pend_d1", 16'(ifc.dec_bcd), 16'hF);
      tick_to(45);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
